dsp_stream_router: RTL and testbench

Parametrised successor to the DSP top-level stream mux. It routes one Avalon-ST packet stream from the DMA to one of N_ENG processing engines (FIR, DFT, TEA, ...) and returns the selected engine's output stream. Engine selection is latched per packet, so a control-register change never splits a packet. The block adds optional byte swapping on both paths, a registered output skid buffer, a completed-packet counter and orphan-beat error detection. It sits between the DMA stream ports and the engine wrappers.

---
 rtl/dsp_stream_router.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_dsp_stream_router.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : dsp_stream_router
// Purpose  : Routes one Avalon-ST packet stream from the DMA to one of N_ENG
//            processing engines and returns that engine's output stream
//            through a registered 2-entry skid buffer. The engine is latched
//            per packet, so CSR changes never split a packet. Optional byte
//            swapping on both paths, completed-packet counter and sticky
//            orphan-beat error flag.
// Ports    :
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_enable, cfg_sel  CSR router enable and engine index
//   err_clr              pulse clearing err_orphan
//   sink_*               input stream from the DMA
//   source_*             output stream to the DMA (registered)
//   eng_sink_*           stream to the engines (data/sop/eop broadcast)
//   eng_source_*         engine output streams (engine i in slice i)
//   active_sel, busy     latched engine index, FSM-not-idle
//   pkt_count            completed packets (wraps at 16 bits)
//   err_orphan           sticky: non-SOP beat received while idle
// Revision : 1.0 - initial release
// ============================================================================
module dsp_stream_router #(
    parameter int DATA_W     = 32,
    parameter int N_ENG      = 3,
    parameter int SEL_W      = $clog2(N_ENG),
    parameter int SWAP_BYTES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_enable,
    input  logic [SEL_W-1:0]         cfg_sel,
    input  logic                     err_clr,
    input  logic [DATA_W-1:0]        sink_data,
    input  logic                     sink_valid,
    input  logic                     sink_sop,
    input  logic                     sink_eop,
    output logic                     sink_ready,
    output logic [DATA_W-1:0]        source_data,
    output logic                     source_valid,
    output logic                     source_sop,
    output logic                     source_eop,
    input  logic                     source_ready,
    output logic [DATA_W-1:0]        eng_sink_data,
    output logic [N_ENG-1:0]         eng_sink_valid,
    output logic                     eng_sink_sop,
    output logic                     eng_sink_eop,
    input  logic [N_ENG-1:0]         eng_sink_ready,
    input  logic [N_ENG*DATA_W-1:0]  eng_source_data,
    input  logic [N_ENG-1:0]         eng_source_valid,
    input  logic [N_ENG-1:0]         eng_source_sop,
    input  logic [N_ENG-1:0]         eng_source_eop,
    output logic [N_ENG-1:0]         eng_source_ready,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy,
    output logic [15:0]              pkt_count,
    output logic                     err_orphan
);

    localparam int               C_BYTES = DATA_W / 8;
    localparam logic [SEL_W:0]   C_N_ENG = (SEL_W + 1)'(N_ENG);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] cond_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (SWAP_BYTES != 0) begin
            for (int b = 0; b < C_BYTES; b++) begin
                r[b*8 +: 8] = d[(C_BYTES-1-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [SEL_W-1:0]    active_sel_q, active_sel_d;
    logic                in_done_q,    in_done_d;
    logic                out_done_q,   out_done_d;
    logic [15:0]         pkt_count_q,  pkt_count_d;
    logic                err_orphan_q, err_orphan_d;
    logic                busy_q,       busy_d;

    // Skid buffer: the head entry is the source port register itself,
    // the second entry only fills when the head is stalled.
    logic [DATA_W-1:0]   source_data_q,  source_data_d;
    logic                source_valid_q, source_valid_d;
    logic                source_sop_q,   source_sop_d;
    logic                source_eop_q,   source_eop_d;
    logic [DATA_W-1:0]   skid_data_q,    skid_data_d;
    logic                skid_valid_q,   skid_valid_d;
    logic                skid_sop_q,     skid_sop_d;
    logic                skid_eop_q,     skid_eop_d;

    // ------------------------------------------------------------------------
    // Selected-engine muxes
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_sop;
    logic                w_sel_eop;
    logic                w_sel_sink_ready;

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                w_sel_data  = eng_source_data[i*DATA_W +: DATA_W];
                w_sel_valid = eng_source_valid[i];
                w_sel_sop   = eng_source_sop[i];
                w_sel_eop   = eng_source_eop[i];
            end
        end
    end

    always_comb begin
        w_sel_sink_ready = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                w_sel_sink_ready = eng_sink_ready[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sink path
    // ------------------------------------------------------------------------
    logic w_cfg_ok;
    logic w_sink_ready;
    logic w_in_acc;
    logic w_in_eop_acc;
    logic w_sink_route;
    logic w_out_ready;
    logic w_out_push;
    logic w_out_eop_acc;
    logic w_pop;

    assign w_cfg_ok = cfg_enable && ({1'b0, cfg_sel} < C_N_ENG);

    // In IDLE a SOP beat must stay on the bus until ACTIVE forwards it, so
    // ready is withheld for exactly that beat; orphan beats are swallowed.
    always_comb begin
        w_sink_ready = 1'b0;
        case (state_q)
            S_IDLE:   w_sink_ready = w_cfg_ok && !(sink_valid && sink_sop);
            S_ACTIVE: w_sink_ready = w_sel_sink_ready;
            default:  w_sink_ready = 1'b0;
        endcase
    end

    assign sink_ready    = w_sink_ready;
    assign w_in_acc      = sink_valid && w_sink_ready;
    assign w_in_eop_acc  = w_in_acc && sink_eop && (state_q == S_ACTIVE);
    assign w_sink_route  = (state_q == S_ACTIVE) && sink_valid;

    assign eng_sink_data = cond_swap(sink_data);
    assign eng_sink_sop  = sink_sop;
    assign eng_sink_eop  = sink_eop;

    // Output side accepts while the buffer has a free entry; the decision
    // depends only on registered occupancy, never on source_ready.
    assign w_out_ready   = (state_q != S_IDLE) && !skid_valid_q;
    assign w_out_push    = w_sel_valid && w_out_ready;
    assign w_out_eop_acc = w_out_push && w_sel_eop;
    assign w_pop         = source_valid_q && source_ready;

    for (genvar g = 0; g < N_ENG; g++) begin : g_eng
        localparam logic [SEL_W-1:0] C_IDX = SEL_W'(g);
        assign eng_sink_valid[g]   = w_sink_route && (active_sel_q == C_IDX);
        assign eng_source_ready[g] = w_out_ready  && (active_sel_q == C_IDX);
    end

    // ------------------------------------------------------------------------
    // Skid buffer next state
    // ------------------------------------------------------------------------
    always_comb begin
        source_data_d  = source_data_q;
        source_valid_d = source_valid_q;
        source_sop_d   = source_sop_q;
        source_eop_d   = source_eop_q;
        skid_data_d    = skid_data_q;
        skid_valid_d   = skid_valid_q;
        skid_sop_d     = skid_sop_q;
        skid_eop_d     = skid_eop_q;

        if (w_pop) begin
            if (skid_valid_q) begin
                source_data_d = skid_data_q;
                source_sop_d  = skid_sop_q;
                source_eop_d  = skid_eop_q;
                skid_valid_d  = 1'b0;
            end else begin
                source_valid_d = 1'b0;
            end
        end

        if (w_out_push) begin
            if (!source_valid_d) begin
                source_data_d  = cond_swap(w_sel_data);
                source_sop_d   = w_sel_sop;
                source_eop_d   = w_sel_eop;
                source_valid_d = 1'b1;
            end else begin
                skid_data_d  = cond_swap(w_sel_data);
                skid_sop_d   = w_sel_sop;
                skid_eop_d   = w_sel_eop;
                skid_valid_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    logic w_orphan;

    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        in_done_d    = in_done_q;
        out_done_d   = out_done_q;
        w_orphan     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sink_valid && w_cfg_ok) begin
                    if (sink_sop) begin
                        active_sel_d = cfg_sel;
                        in_done_d    = 1'b0;
                        out_done_d   = 1'b0;
                        state_d      = S_ACTIVE;
                    end else begin
                        w_orphan = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_out_eop_acc) begin
                    out_done_d = 1'b1;
                end
                // An output EOP in this very cycle counts as already done.
                if (w_in_eop_acc) begin
                    in_done_d = 1'b1;
                    state_d   = (out_done_q || w_out_eop_acc) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_eop_acc) begin
                    out_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pkt_count_d = pkt_count_q;
        if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end

        err_orphan_d = err_orphan_q;
        if (w_orphan) begin
            err_orphan_d = 1'b1;
        end else if (err_clr) begin
            err_orphan_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            active_sel_q   <= '0;
            in_done_q      <= 1'b0;
            out_done_q     <= 1'b0;
            pkt_count_q    <= '0;
            err_orphan_q   <= 1'b0;
            busy_q         <= 1'b0;
            source_data_q  <= '0;
            source_valid_q <= 1'b0;
            source_sop_q   <= 1'b0;
            source_eop_q   <= 1'b0;
            skid_data_q    <= '0;
            skid_valid_q   <= 1'b0;
            skid_sop_q     <= 1'b0;
            skid_eop_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_sel_q   <= active_sel_d;
            in_done_q      <= in_done_d;
            out_done_q     <= out_done_d;
            pkt_count_q    <= pkt_count_d;
            err_orphan_q   <= err_orphan_d;
            busy_q         <= busy_d;
            source_data_q  <= source_data_d;
            source_valid_q <= source_valid_d;
            source_sop_q   <= source_sop_d;
            source_eop_q   <= source_eop_d;
            skid_data_q    <= skid_data_d;
            skid_valid_q   <= skid_valid_d;
            skid_sop_q     <= skid_sop_d;
            skid_eop_q     <= skid_eop_d;
        end
    end

    assign source_data  = source_data_q;
    assign source_valid = source_valid_q;
    assign source_sop   = source_sop_q;
    assign source_eop   = source_eop_q;
    assign active_sel   = active_sel_q;
    assign busy         = busy_q;
    assign pkt_count    = pkt_count_q;
    assign err_orphan   = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_stream_router
// Purpose  : Directed self-checking bench for dsp_stream_router with
//            behavioural echo / manually driven engines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_stream_router;

    localparam int DATA_W = 32;
    localparam int N_ENG  = 3;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_enable;
    logic [SEL_W-1:0]        cfg_sel;
    logic                    err_clr;
    logic [DATA_W-1:0]       sink_data;
    logic                    sink_valid, sink_sop, sink_eop, sink_ready;
    logic [DATA_W-1:0]       source_data;
    logic                    source_valid, source_sop, source_eop, source_ready;
    logic [DATA_W-1:0]       eng_sink_data;
    logic [N_ENG-1:0]        eng_sink_valid;
    logic                    eng_sink_sop, eng_sink_eop;
    logic [N_ENG-1:0]        eng_sink_ready;
    logic [N_ENG*DATA_W-1:0] eng_source_data;
    logic [N_ENG-1:0]        eng_source_valid, eng_source_sop, eng_source_eop;
    logic [N_ENG-1:0]        eng_source_ready;
    logic [SEL_W-1:0]        active_sel;
    logic                    busy;
    logic [15:0]             pkt_count;
    logic                    err_orphan;

    // Engine model: echo mode passes each engine input straight back out.
    logic                    echo;
    logic [N_ENG-1:0]        m_sink_ready, m_src_valid, m_src_sop, m_src_eop;
    logic [N_ENG*DATA_W-1:0] m_src_data;

    assign eng_sink_ready   = echo ? eng_source_ready : m_sink_ready;
    assign eng_source_valid = echo ? eng_sink_valid : m_src_valid;
    assign eng_source_sop   = echo ? {N_ENG{eng_sink_sop}} : m_src_sop;
    assign eng_source_eop   = echo ? {N_ENG{eng_sink_eop}} : m_src_eop;
    assign eng_source_data  = echo ? {N_ENG{eng_sink_data}} : m_src_data;

    always #5 clk = ~clk;

    dsp_stream_router #(
        .DATA_W(DATA_W), .N_ENG(N_ENG), .SEL_W(SEL_W), .SWAP_BYTES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_sel(cfg_sel),
        .err_clr(err_clr), .sink_data(sink_data), .sink_valid(sink_valid),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready), .eng_sink_data(eng_sink_data),
        .eng_sink_valid(eng_sink_valid), .eng_sink_sop(eng_sink_sop),
        .eng_sink_eop(eng_sink_eop), .eng_sink_ready(eng_sink_ready),
        .eng_source_data(eng_source_data), .eng_source_valid(eng_source_valid),
        .eng_source_sop(eng_source_sop), .eng_source_eop(eng_source_eop),
        .eng_source_ready(eng_source_ready), .active_sel(active_sel),
        .busy(busy), .pkt_count(pkt_count), .err_orphan(err_orphan)
    );

    int checks   = 0;
    int failures = 0;

    // Monitors: logs of accepted beats and an independent buffer occupancy.
    logic [31:0] eng_log_data[$];
    int          eng_log_idx[$];
    logic [31:0] src_log_data[$];
    logic        src_log_sop[$];
    logic        src_log_eop[$];
    int          occ, max_occ, full_viol;

    always @(negedge clk) begin
        if (!rst_n) begin
            eng_log_data.delete(); eng_log_idx.delete();
            src_log_data.delete(); src_log_sop.delete(); src_log_eop.delete();
            occ = 0; max_occ = 0; full_viol = 0;
        end else begin
            for (int i = 0; i < N_ENG; i++) begin
                if (eng_sink_valid[i] && eng_sink_ready[i]) begin
                    eng_log_idx.push_back(i);
                    eng_log_data.push_back(eng_sink_data);
                end
            end
            if (busy && ((eng_source_ready == '0) != (occ == 2))) full_viol++;
            if (source_valid && source_ready) begin
                src_log_data.push_back(source_data);
                src_log_sop.push_back(source_sop);
                src_log_eop.push_back(source_eop);
                occ = occ - 1;
            end
            if ((eng_source_valid & eng_source_ready) != '0) occ = occ + 1;
            if (occ > max_occ) max_occ = occ;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
        err_clr = 1'b0; source_ready = 1'b1;
        m_sink_ready = '1; m_src_valid = '0; m_src_sop = '0; m_src_eop = '0;
        m_src_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic sop, input logic eop);
        logic acc;
        int   n;
        sink_valid = 1'b1; sink_data = d; sink_sop = sop; sink_eop = eop;
        n = 0;
        do begin
            @(negedge clk); acc = sink_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL beat_accept: data %h not accepted, ready=%0b required 1", d, acc);
        end
    endtask

    task automatic wait_idle_drained(input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while ((busy || source_valid) && n < 200);
        checks++;
        if (busy !== 1'b0 || source_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%0b source_valid=%0b required 0/0", tag, busy, source_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; echo = 1'b1; cfg_enable = 1'b0; cfg_sel = '0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
        err_clr = 1'b0; source_ready = 1'b1;
        m_sink_ready = '0; m_src_valid = '0; m_src_sop = '0; m_src_eop = '0;
        m_src_data = '0;
        #3;
        checks++;
        if ({source_valid, source_sop, source_eop} !== 3'b000 || source_data !== '0) begin
            failures++;
            $display("FAIL reset_source: v/s/e=%b data=%h required 000/0",
                     {source_valid, source_sop, source_eop}, source_data);
        end
        checks++;
        if (busy !== 1'b0 || pkt_count !== 16'd0 || err_orphan !== 1'b0 || active_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%0b cnt=%0d err=%0b sel=%0d required 0/0/0/0",
                     busy, pkt_count, err_orphan, active_sel);
        end
        checks++;
        if (eng_sink_valid !== 3'b000 || eng_source_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_eng: valid=%b ready=%b required 000/000", eng_sink_valid, eng_source_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] pkt [4];
        logic [31:0] exp_eng [4];
        pkt[0] = 32'h11223344; pkt[1] = 32'h55667788; pkt[2] = 32'h99AABBCC; pkt[3] = 32'hDDEEFF00;
        exp_eng[0] = 32'h44332211; exp_eng[1] = 32'h88776655;
        exp_eng[2] = 32'hCCBBAA99; exp_eng[3] = 32'h00FFEEDD;
        do_reset(); echo = 1'b1; cfg_enable = 1'b1; cfg_sel = 2'd0;
        @(negedge clk);
        checks++;
        if (sink_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: sink_ready=%0b required 1", sink_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(pkt[i], i == 0, i == 3);
            if (i == 0) begin
                checks++;
                if (source_valid !== 1'b1 || source_data !== 32'h11223344 || source_sop !== 1'b1) begin
                    failures++;
                    $display("FAIL latency: v=%0b data=%h sop=%0b required 1/11223344/1",
                             source_valid, source_data, source_sop);
                end
            end
        end
        sink_valid = 1'b0;
        wait_idle_drained("basic");
        checks++;
        if (eng_log_data.size() != 4 || src_log_data.size() != 4) begin
            failures++;
            $display("FAIL basic_count: eng=%0d src=%0d required 4/4", eng_log_data.size(), src_log_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (eng_log_idx[i] != 0 || eng_log_data[i] !== exp_eng[i]) begin
                    failures++;
                    $display("FAIL basic_eng[%0d]: idx=%0d data=%h required 0/%h",
                             i, eng_log_idx[i], eng_log_data[i], exp_eng[i]);
                end
                checks++;
                if (src_log_data[i] !== pkt[i] || src_log_sop[i] !== (i == 0) || src_log_eop[i] !== (i == 3)) begin
                    failures++;
                    $display("FAIL basic_src[%0d]: data=%h sop=%0b eop=%0b required %h/%0b/%0b",
                             i, src_log_data[i], src_log_sop[i], src_log_eop[i], pkt[i], i == 0, i == 3);
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_pkt_count: got %0d required 1", pkt_count);
        end
    endtask

    task automatic test_mid_switch();
        do_reset(); echo = 1'b1; cfg_enable = 1'b1; cfg_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(32'hA0000001 + i, i == 0, i == 2);
            if (i == 0) cfg_sel = 2'd2;
        end
        sink_valid = 1'b0;
        wait_idle_drained("switch_a");
        for (int i = 0; i < 2; i++) drive_beat(32'hB0000001 + i, i == 0, i == 1);
        sink_valid = 1'b0;
        wait_idle_drained("switch_b");
        checks++;
        if (eng_log_idx.size() != 5) begin
            failures++;
            $display("FAIL switch_count: eng beats=%0d required 5", eng_log_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (eng_log_idx[i] != ((i < 3) ? 1 : 2)) begin
                    failures++;
                    $display("FAIL switch_route[%0d]: engine=%0d required %0d", i, eng_log_idx[i], (i < 3) ? 1 : 2);
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd2 || active_sel !== 2'd2) begin
            failures++;
            $display("FAIL switch_status: cnt=%0d sel=%0d required 2/2", pkt_count, active_sel);
        end
    endtask

    task automatic test_early_out_eop();
        do_reset(); echo = 1'b0; cfg_enable = 1'b1; cfg_sel = 2'd0; m_sink_ready = '1;
        drive_beat(32'h01020304, 1'b1, 1'b0);
        sink_valid = 1'b0;
        m_src_valid = 3'b001; m_src_sop = 3'b001; m_src_eop = 3'b001;
        m_src_data = {64'd0, 32'h000000A5};
        @(negedge clk);
        checks++;
        if (eng_source_ready !== 3'b001) begin
            failures++;
            $display("FAIL early_eng_ready: got %b required 001", eng_source_ready);
        end
        @(posedge clk); #1;
        m_src_valid = '0; m_src_sop = '0; m_src_eop = '0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL early_busy_mid: busy=%0b required 1", busy);
        end
        drive_beat(32'h05060708, 1'b0, 1'b1);
        sink_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL early_direct_idle: busy=%0b cnt=%0d required 0/1", busy, pkt_count);
        end
        wait_idle_drained("early");
        checks++;
        if (src_log_data.size() != 1 || src_log_data[0] !== 32'hA5000000 ||
            src_log_sop[0] !== 1'b1 || src_log_eop[0] !== 1'b1) begin
            failures++;
            $display("FAIL early_src: n=%0d data=%h required 1/a5000000", src_log_data.size(), src_log_data[0]);
        end
        checks++;
        if (eng_log_data.size() != 2 || eng_log_data[1] !== 32'h08070605) begin
            failures++;
            $display("FAIL early_eng: n=%0d data=%h required 2/08070605", eng_log_data.size(), eng_log_data[1]);
        end
    endtask

    task automatic test_backpressure();
        do_reset(); echo = 1'b1; cfg_enable = 1'b1; cfg_sel = 2'd2;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_beat(32'hC0DE0000 + i, i == 0, i == 7);
                sink_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    source_ready = ~source_ready;
                    @(posedge clk); #1;
                end
            end
        join
        source_ready = 1'b1;
        wait_idle_drained("bp");
        checks++;
        if (src_log_data.size() != 8) begin
            failures++;
            $display("FAIL bp_count: got %0d beats required 8", src_log_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (src_log_data[i] !== 32'hC0DE0000 + i || src_log_eop[i] !== (i == 7)) begin
                    failures++;
                    $display("FAIL bp_beat[%0d]: data=%h eop=%0b required %h/%0b",
                             i, src_log_data[i], src_log_eop[i], 32'hC0DE0000 + i, i == 7);
                end
            end
        end
        checks++;
        if (max_occ != 2 || full_viol != 0) begin
            failures++;
            $display("FAIL bp_buffer: max_occ=%0d ready_violations=%0d required 2/0", max_occ, full_viol);
        end
    endtask

    task automatic test_orphan();
        do_reset(); echo = 1'b1; cfg_enable = 1'b1; cfg_sel = 2'd0;
        drive_beat(32'hDEAD0001, 1'b0, 1'b0);
        sink_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_orphan !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd0 || eng_log_data.size() != 0) begin
            failures++;
            $display("FAIL orphan_set: err=%0b busy=%0b cnt=%0d eng=%0d required 1/0/0/0",
                     err_orphan, busy, pkt_count, eng_log_data.size());
        end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        checks++;
        if (err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL orphan_clr: err=%0b required 0", err_orphan);
        end
        err_clr = 1'b1;
        drive_beat(32'hDEAD0002, 1'b0, 1'b0);
        sink_valid = 1'b0; err_clr = 1'b0;
        checks++;
        if (err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_set_wins: err=%0b required 1", err_orphan);
        end
    endtask

    task automatic test_disabled_and_reset();
        int bad;
        do_reset(); echo = 1'b1; cfg_enable = 1'b1; cfg_sel = 2'd3;
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 32'h12345678;
        bad = 0;
        repeat (20) begin @(negedge clk); if (sink_ready !== 1'b0 || busy !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sel_out_of_range: %0d cycles ready/busy, required 0", bad);
        end
        cfg_sel = 2'd0; cfg_enable = 1'b0;
        bad = 0;
        repeat (20) begin @(negedge clk); if (sink_ready !== 1'b0 || busy !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL disabled: %0d cycles ready/busy, required 0", bad);
        end
        @(posedge clk); #1;
        cfg_enable = 1'b1; source_ready = 1'b0;
        drive_beat(32'h00000001, 1'b1, 1'b0);
        drive_beat(32'h00000002, 1'b0, 1'b0);
        sink_data = 32'h00000003; sink_sop = 1'b0;
        checks++;
        if (source_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: v=%0b busy=%0b required 1/1", source_valid, busy);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({source_valid, source_sop, source_eop} !== 3'b000 || source_data !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_source: v/s/e=%b data=%h busy=%0b required 000/0/0",
                     {source_valid, source_sop, source_eop}, source_data, busy);
        end
        checks++;
        if (eng_sink_valid !== 3'b000 || eng_source_ready !== 3'b000 || active_sel !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_eng: valid=%b ready=%b sel=%0d required 000/000/0",
                     eng_sink_valid, eng_source_ready, active_sel);
        end
        sink_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_switch();
        test_early_out_eop();
        test_backpressure();
        test_orphan();
        test_disabled_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
